stream_demux_1_4: RTL and testbench
===================================

# stream_demux_1_4

Packet-aware 1:4 stream demultiplexer with valid/ready handshakes: the distributing counterpart of the 4:1 selector, routing one input stream to one of four output streams. The destination is taken from `in_sel` on the first beat of each packet and held until the beat carrying `in_last`. Each output has its own 2-entry FIFO, so a stalled output never blocks traffic already queued for the other outputs. The block sits between a single producer and four independent consumers in the datapath.

## Interface
- `W`, default 4: data width in bits.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  input beat present.
- `in_ready`  output  1  input beat accepted when `in_valid && in_ready`.
- `in_data`  input  W  input payload.
- `in_sel`  input  2  destination index 0..3; sampled only on the first beat of a packet.
- `in_last`  input  1  final beat of the packet.
- `out_valid[k]`, k = 0..3  output  1 each  output k has a beat available.
- `out_ready[k]`  input  1 each  consumer k accepts the beat.
- `out_data[k]`  output  W each  payload at the head of FIFO k.
- `out_last[k]`  output  1 each  `in_last` stored with that beat.
- `busy`  output  1  high while a packet is open (state LOCKED).

## Operation
- State machine:
  - IDLE: no packet open. Destination `d = in_sel`, combinational.
  - LOCKED: packet open. `d = lock_sel`, a register.
  - IDLE -> LOCKED: on an accepted beat with `in_last = 0`. The same edge captures `lock_sel <= in_sel`.
  - LOCKED -> IDLE: on an accepted beat with `in_last = 1`.
  - An accepted single-beat packet (`in_last = 1` in IDLE) stays in IDLE.
- In LOCKED, `in_sel` is ignored; changes to it mid-packet have no effect.
- `in_ready = (count[d] != 2)`.
  - Depends on `out_ready` only through registered FIFO counts, so there is no combinational path from `out_ready` to `in_ready`.
  - `in_ready` may be high while `in_valid` is low.
- Accepted beat: `{in_data, in_last}` is written to FIFO d only. Other FIFOs are untouched.
- FIFO k:
  - Depth 2, with `count[k]` in 0..2.
  - `out_valid[k] = (count[k] != 0)`.
  - `out_data[k]` and `out_last[k]` show the head entry.
  - Pop on `out_valid[k] && out_ready[k]`.
  - Push and pop in the same cycle: count unchanged, order preserved, 1 beat/cycle throughput.
  - Push when full never occurs, because `in_ready` gates it.
- Outputs drain independently. Beats of one packet are never interleaved with another packet on the same output.
- `busy` is high exactly in LOCKED.
- Reset, including assertion mid-packet or with FIFOs occupied:
  - State goes to IDLE, all counts to 0, `lock_sel` to 0.
  - Queued beats are discarded.
  - Outputs: `out_valid` = 0, `busy` = 0, `out_data`/`out_last` = 0.
  - `in_ready` evaluates to 1 (count[d] = 0).

## Timing
- Latency: a beat accepted at edge N is visible on `out_valid[d]`/`out_data[d]` after edge N, i.e. in cycle N+1.
- Throughput: 1 beat/cycle per active output when the consumer holds `out_ready` high.
- Backpressure: with consumer d stalled, exactly 2 beats are accepted, then `in_ready` drops the same cycle count reaches 2. It rises again in the cycle after the pop edge.
- Packet switch: the last beat of a packet to output A and the first beat of the next packet to output B may be accepted on consecutive edges, with no bubble.
- Reset takes effect immediately on assertion. The first beat can be accepted at the first edge after deassertion.

## Test plan
- Reset values:
  - Stimulus: assert `rst` mid-packet with FIFO 2 holding 2 beats.
  - Required: immediately `out_valid` = 4'b0000 and `busy` = 0.
  - After deassertion: `in_ready` = 1; a new 1-beat packet with `in_sel` = 1 and `in_data` = 4'hA appears on output 1 only.
- Routing:
  - Stimulus: single-beat packets `in_data` = 4'h1/4'h2/4'h3/4'h4, with `in_sel` = 0/1/2/3, on consecutive cycles, all `out_ready` = 1.
  - Required: each value appears on its own output exactly one cycle after acceptance, `out_last` = 1, no other output valid.
- Lock:
  - Stimulus: 3-beat packet (4'h5, 4'h6, 4'h7) starting with `in_sel` = 2; `in_sel` set to 0 on beats 2–3.
  - Required: all three beats are on output 2; `busy` is high from after beat 1 until after beat 3; output 0 stays empty.
- Backpressure:
  - Stimulus: `out_ready[3]` = 0, 4-beat packet to output 3.
  - Required: 2 beats accepted, then `in_ready` = 0.
  - Then: raising `out_ready[3]` drains 4'h… in order, `in_ready` recovers, all 4 beats are delivered in order, `out_last` only on the 4th.
- Isolation:
  - Stimulus: output 0 stalled and full; then a new packet to output 1.
  - Required: `in_ready` = 1 and the packet flows to output 1 at full rate while output 0 holds its 2 beats unchanged.
- Simultaneous push/pop:
  - Stimulus: continuous 8-beat packet to output 2 with `out_ready[2]` = 1.
  - Required: `count[2]` stays 1 in steady state, `in_ready` never drops, 8 beats delivered in 8 consecutive cycles.

Source files
------------

// File: rtl/stream_demux_1_4.sv
// Packet-aware 1:4 valid/ready stream demultiplexer with a 2-entry FIFO per output.
// The destination is sampled on a packet's first beat and held until its last beat.
module stream_demux_1_4 #(
  parameter int W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_data,
  input  logic [1:0]        in_sel,
  input  logic              in_last,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [3:0][W-1:0] out_data,
  output logic [3:0]        out_last,
  output logic              busy
);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t          r_state;
  logic [1:0]      r_lock_sel;
  logic [3:0][1:0] r_cnt;
  logic [3:0][W:0] r_head;
  logic [3:0][W:0] r_tail;

  logic [1:0]      w_dst;
  logic            w_acc;
  logic [W:0]      w_beat;
  logic [3:0]      w_push;
  logic [3:0]      w_pop;

  assign w_dst    = (r_state == ST_LOCKED) ? r_lock_sel : in_sel;
  assign in_ready = (r_cnt[w_dst] != 2'd2);
  assign w_acc    = in_valid && in_ready;
  assign w_beat   = {in_data, in_last};
  assign busy     = (r_state == ST_LOCKED);

  // Output view: payload is forced to zero whenever a FIFO is empty
  always_comb begin
    w_push    = '0;
    w_pop     = '0;
    out_valid = '0;
    out_data  = '0;
    out_last  = '0;
    for (int k = 0; k < 4; k++) begin
      out_valid[k] = (r_cnt[k] != 2'd0);
      w_push[k]    = w_acc && (w_dst == 2'(k));
      w_pop[k]     = out_valid[k] && out_ready[k];
      out_data[k]  = out_valid[k] ? r_head[k][W:1] : '0;
      out_last[k]  = out_valid[k] & r_head[k][0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_lock_sel <= 2'd0;
    end else if (w_acc) begin
      case (r_state)
        ST_IDLE: begin
          if (!in_last) begin
            r_state    <= ST_LOCKED;
            r_lock_sel <= in_sel;
          end
        end
        ST_LOCKED: begin
          if (in_last) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        case ({w_push[k], w_pop[k]})
          2'b10:   r_cnt[k] <= r_cnt[k] + 2'd1;
          2'b01:   r_cnt[k] <= r_cnt[k] - 2'd1;
          default: r_cnt[k] <= r_cnt[k];
        endcase
      end
    end
  end

  // Storage: head shifts up from tail on a pop from a full FIFO; a push lands in
  // the first slot that is free after this cycle's pop
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (w_pop[k] && (r_cnt[k] == 2'd2)) r_head[k] <= r_tail[k];
      if (w_push[k]) begin
        if ((r_cnt[k] == 2'd0) || ((r_cnt[k] == 2'd1) && w_pop[k]))
          r_head[k] <= w_beat;
        else
          r_tail[k] <= w_beat;
      end
    end
  end

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Bench for stream_demux_1_4: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the packet router.
module tb_stream_demux_1_4;
  localparam int W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_data;
  logic [1:0]        in_sel;
  logic              in_last;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;
  logic [3:0][W-1:0] out_data;
  logic [3:0]        out_last;
  logic              busy;

  int total = 0;
  int bad   = 0;

  logic [W:0] q[4][$];
  bit         m_open;
  logic [1:0] m_sel;

  stream_demux_1_4 #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] m_dst();
    return m_open ? m_sel : in_sel;
  endfunction

  function automatic bit m_ready();
    return q[m_dst()].size() != 2;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 4; k++) q[k].delete();
    m_open = 1'b0;
    m_sel  = 2'd0;
  endtask

  // One clock cycle: compare all outputs with the model, then advance the model
  task automatic cyc();
    logic [1:0] d;
    bit         acc;
    #3;
    d   = m_dst();
    acc = in_valid && m_ready();
    chk("in_ready", in_ready, m_ready());
    chk("busy", busy, m_open);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("out_valid%0d", k), out_valid[k], q[k].size() != 0);
      if (q[k].size() != 0) begin
        chk($sformatf("out_data%0d", k), out_data[k], q[k][0][W:1]);
        chk($sformatf("out_last%0d", k), out_last[k], q[k][0][0]);
      end
    end
    @(posedge clk);
    for (int k = 0; k < 4; k++)
      if (q[k].size() != 0 && out_ready[k]) void'(q[k].pop_front());
    if (acc) begin
      q[d].push_back({in_data, in_last});
      if (!m_open && !in_last) begin
        m_open = 1'b1;
        m_sel  = in_sel;
      end else if (m_open && in_last) begin
        m_open = 1'b0;
      end
    end
    #1;
  endtask

  task automatic beat(input logic [1:0] sel, input logic [W-1:0] data, input logic last);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    in_last  = last;
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 0; in_data = '0; in_sel = '0; in_last = 0; out_ready = '0;
    m_reset();
    @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;
    cyc();

    // Routing: one single-beat packet per output on consecutive cycles
    out_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      beat(2'(i), 4'(i + 1), 1'b1);
      cyc();
    end
    in_valid = 0;
    #1 chk("route_out3", out_valid, 4'b1000);
    chk("route_data3", out_data[3], 4'h4);
    cyc(); cyc();

    // Lock: in_sel changes mid-packet are ignored
    beat(2'd2, 4'h5, 1'b0); cyc();
    beat(2'd0, 4'h6, 1'b0); #1 chk("lock_busy", busy, 1'b1); cyc();
    beat(2'd0, 4'h7, 1'b1); cyc();
    in_valid = 0;
    #1 chk("lock_idle", busy, 1'b0);
    chk("lock_out0_empty", out_valid[0], 1'b0);
    cyc(); cyc();

    // Backpressure: consumer 3 stalled, 4-beat packet
    out_ready = 4'b0111;
    n = 0;
    for (int c = 0; c < 30 && n < 4; c++) begin
      bit a;
      beat(2'd3, 4'(8 + n), n == 3);
      if (c == 5) out_ready[3] = 1'b1;
      if (c == 2) begin
        #1 chk("bp_stall_ready", in_ready, 1'b0);
        chk("bp_count", n, 2);
      end
      a = m_ready();
      cyc();
      if (a) n++;
    end
    chk("bp_all_accepted", n, 4);
    in_valid = 0;
    repeat (4) cyc();

    // Isolation: output 0 stalled and full, packet to output 1 flows
    out_ready = 4'b1110;
    beat(2'd0, 4'hC, 1'b0); cyc();
    beat(2'd0, 4'hD, 1'b1); cyc();
    for (int i = 0; i < 3; i++) begin
      beat(2'd1, 4'(14 + i), i == 2);
      #1 chk("iso_ready", in_ready, 1'b1);
      cyc();
    end
    in_valid = 0;
    #1 chk("iso_out0_head", out_data[0], 4'hC);
    chk("iso_out0_valid", out_valid[0], 1'b1);
    cyc();
    out_ready = 4'hF;
    repeat (3) cyc();

    // Simultaneous push/pop: 8-beat packet to output 2 at full rate
    for (int i = 0; i < 8; i++) begin
      beat(2'd2, 4'(i), i == 7);
      #1 chk("pp_ready", in_ready, 1'b1);
      cyc();
    end
    in_valid = 0;
    repeat (2) cyc();

    // Reset mid-packet with FIFO 2 full
    out_ready = 4'b1011;
    beat(2'd2, 4'h3, 1'b0); cyc();
    beat(2'd2, 4'h9, 1'b0); cyc();
    beat(2'd2, 4'hB, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 4'b0000);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_data", out_data, '0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    m_reset();
    in_valid = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 4'hF;
    beat(2'd1, 4'hA, 1'b1);
    cyc();
    in_valid = 0;
    #1 chk("post_rst_out", out_valid, 4'b0010);
    chk("post_rst_data", out_data[1], 4'hA);
    cyc(); cyc();

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sel    = 2'($urandom);
      in_data   = W'($urandom);
      in_last   = ($urandom_range(0, 2) == 0);
      out_ready = 4'($urandom);
      cyc();
    end
    in_valid  = 0;
    out_ready = 4'hF;
    repeat (4) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
